// File: rtl/down_timer16_if.sv
// rtl/down_timer16_if.sv - control/status bundle for the prescaled down-timer
interface down_timer16_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] period;
    logic             repeat_en;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    modport master (
        output start, period, repeat_en, abort,
        input  count, busy, done
    );

    modport slave (
        input  start, period, repeat_en, abort,
        output count, busy, done
    );
endinterface

// File: rtl/down_timer16.sv
// rtl/down_timer16.sv - loadable prescaled down-counter with done pulse and auto-reload
module down_timer16 #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 1
) (
    input  logic          clk,
    input  logic          rst,
    down_timer16_if.slave tmr
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] count_q, count_n;
    logic [WIDTH-1:0] reload_q, reload_n;
    logic             rpt_q, rpt_n;
    logic [PW-1:0]    presc_q, presc_n;
    logic             done_q, done_n;
    logic [WIDTH-1:0] count_dec;
    logic             tick;

    // Ripple-borrow decrement: a borrow enters bit 0 and propagates through zeros.
    always_comb begin : borrow_chain
        logic borrow;
        borrow    = 1'b1;
        count_dec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_dec[i] = count_q[i] ^ borrow;
            borrow       = ~count_q[i] & borrow;
        end
    end

    assign tick = (presc_q == PRE_LAST);

    // Next-state and datapath updates; abort outranks the terminal tick, which outranks start.
    always_comb begin
        state_n  = state_q;
        count_n  = count_q;
        reload_n = reload_q;
        rpt_n    = rpt_q;
        presc_n  = presc_q;
        done_n   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!tmr.abort && tmr.start) begin
                    if (tmr.period != '0) begin
                        count_n  = tmr.period;
                        reload_n = tmr.period;
                        rpt_n    = tmr.repeat_en;
                        presc_n  = '0;
                        state_n  = RUN;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (tmr.abort) begin
                    count_n = '0;
                    presc_n = '0;
                    state_n = IDLE;
                end else begin
                    presc_n = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        if (count_q == WIDTH'(1)) begin
                            done_n = 1'b1;
                            if (rpt_q) begin
                                count_n = reload_q;
                            end else begin
                                count_n = '0;
                                state_n = IDLE;
                            end
                        end else begin
                            count_n = count_dec;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            rpt_q    <= 1'b0;
            presc_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            count_q  <= count_n;
            reload_q <= reload_n;
            rpt_q    <= rpt_n;
            presc_q  <= presc_n;
            done_q   <= done_n;
        end
    end

    assign tmr.count = count_q;
    assign tmr.busy  = (state_q == RUN);
    assign tmr.done  = done_q;
endmodule

// File: tb/tb_down_timer16.sv
// tb/tb_down_timer16.sv - scoreboard bench for down_timer16 at PRESCALE 1 and 4
module tb_down_timer16;
    logic clk;
    logic rst;

    down_timer16_if #(.WIDTH(16)) b1 ();
    down_timer16_if #(.WIDTH(16)) b4 ();

    down_timer16 #(.WIDTH(16), .PRESCALE(1)) u_p1 (.clk(clk), .rst(rst), .tmr(b1));
    down_timer16 #(.WIDTH(16), .PRESCALE(4)) u_p4 (.clk(clk), .rst(rst), .tmr(b4));

    typedef struct packed {
        logic [15:0] count;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   errors;
    int   checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if (b1.count !== 16'h0) begin errors++; $display("FAIL reset p1 count got=%h exp=0", b1.count); end
        checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL reset p1 busy got=%b exp=0", b1.busy); end
        checks++; if (b1.done !== 1'b0) begin errors++; $display("FAIL reset p1 done got=%b exp=0", b1.done); end
        checks++; if (b4.count !== 16'h0) begin errors++; $display("FAIL reset p4 count got=%h exp=0", b4.count); end
        checks++; if (b4.busy !== 1'b0) begin errors++; $display("FAIL reset p4 busy got=%b exp=0", b4.busy); end
        checks++; if (b4.done !== 1'b0) begin errors++; $display("FAIL reset p4 done got=%b exp=0", b4.done); end
        for (int c = 0; c < 10; c++) sb.push_back(exp_t'{16'h0, 1'b0, 1'b0});
        for (int c = 0; c < 10; c++) begin
            step();
            e = sb.pop_front();
            checks++; if (b1.count !== e.count) begin errors++; $display("FAIL idle count cyc=%0d got=%h exp=%h", c, b1.count, e.count); end
            checks++; if (b1.busy !== e.busy) begin errors++; $display("FAIL idle busy cyc=%0d got=%b exp=%b", c, b1.busy, e.busy); end
            checks++; if (b1.done !== e.done) begin errors++; $display("FAIL idle done cyc=%0d got=%b exp=%b", c, b1.done, e.done); end
        end
    endtask

    task automatic test_oneshot();
        b1.period    = 16'd5;
        b1.repeat_en = 1'b0;
        b1.start     = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            sb.push_back(exp_t'{(c <= 6) ? 16'(6 - c) : 16'h0, (c <= 5), (c == 6)});
        end
        for (int c = 1; c <= 7; c++) begin
            step();
            b1.start = 1'b0;
            e = sb.pop_front();
            checks++; if (b1.count !== e.count) begin errors++; $display("FAIL oneshot count cyc=%0d got=%h exp=%h", c, b1.count, e.count); end
            checks++; if (b1.busy !== e.busy) begin errors++; $display("FAIL oneshot busy cyc=%0d got=%b exp=%b", c, b1.busy, e.busy); end
            checks++; if (b1.done !== e.done) begin errors++; $display("FAIL oneshot done cyc=%0d got=%b exp=%b", c, b1.done, e.done); end
        end
    endtask

    task automatic test_repeat();
        int last_done;
        int n_done;
        last_done    = -1;
        n_done       = 0;
        b4.period    = 16'd3;
        b4.repeat_en = 1'b1;
        b4.start     = 1'b1;
        for (int k = 0; k < 40; k++) begin
            sb.push_back(exp_t'{16'(3 - ((k / 4) % 3)), 1'b1, (k > 0) && (k % 12 == 0)});
        end
        for (int k = 0; k < 40; k++) begin
            step();
            b4.start = 1'b0;
            e = sb.pop_front();
            checks++; if (b4.count !== e.count) begin errors++; $display("FAIL repeat count k=%0d got=%h exp=%h", k, b4.count, e.count); end
            checks++; if (b4.busy !== e.busy) begin errors++; $display("FAIL repeat busy k=%0d got=%b exp=%b", k, b4.busy, e.busy); end
            checks++; if (b4.done !== e.done) begin errors++; $display("FAIL repeat done k=%0d got=%b exp=%b", k, b4.done, e.done); end
            if (b4.done === 1'b1) begin
                if (last_done >= 0) begin
                    checks++; if (k - last_done != 12) begin errors++; $display("FAIL repeat spacing got=%0d exp=12", k - last_done); end
                end
                last_done = k;
                n_done++;
            end
        end
        checks++; if (n_done != 3) begin errors++; $display("FAIL repeat pulses got=%0d exp=3", n_done); end
        b4.abort = 1'b1;
        step();
        b4.abort     = 1'b0;
        b4.repeat_en = 1'b0;
        checks++; if (b4.busy !== 1'b0 || b4.count !== 16'h0 || b4.done !== 1'b0) begin errors++; $display("FAIL repeat stop got=%h/%b/%b exp=0/0/0", b4.count, b4.busy, b4.done); end
    endtask

    task automatic test_abort();
        b1.period = 16'h0010;
        b1.start  = 1'b1;
        step();
        b1.start = 1'b0;
        repeat (4) step();
        checks++; if (b1.count !== 16'd12) begin errors++; $display("FAIL abort precount got=%h exp=000c", b1.count); end
        b1.abort = 1'b1;
        step();
        b1.abort = 1'b0;
        checks++; if (b1.count !== 16'h0 || b1.busy !== 1'b0 || b1.done !== 1'b0) begin errors++; $display("FAIL abort run got=%h/%b/%b exp=0/0/0", b1.count, b1.busy, b1.done); end
        step();
        checks++; if (b1.done !== 1'b0 || b1.busy !== 1'b0) begin errors++; $display("FAIL abort after got=%b/%b exp=0/0", b1.busy, b1.done); end
        b1.period = 16'd9;
        b1.start  = 1'b1;
        b1.abort  = 1'b1;
        step();
        b1.start = 1'b0;
        b1.abort = 1'b0;
        checks++; if (b1.count !== 16'h0 || b1.busy !== 1'b0 || b1.done !== 1'b0) begin errors++; $display("FAIL abort_start got=%h/%b/%b exp=0/0/0", b1.count, b1.busy, b1.done); end
        b1.period = 16'd2;
        b1.start  = 1'b1;
        step();
        b1.start = 1'b0;
        step();
        checks++; if (b1.count !== 16'd1) begin errors++; $display("FAIL abort_term pre got=%h exp=0001", b1.count); end
        b1.abort = 1'b1;
        step();
        b1.abort = 1'b0;
        checks++; if (b1.count !== 16'h0 || b1.busy !== 1'b0 || b1.done !== 1'b0) begin errors++; $display("FAIL abort_term got=%h/%b/%b exp=0/0/0", b1.count, b1.busy, b1.done); end
        step();
        checks++; if (b1.done !== 1'b0) begin errors++; $display("FAIL abort_term late done got=%b exp=0", b1.done); end
    endtask

    task automatic test_zero();
        b1.period = 16'h0;
        b1.start  = 1'b1;
        step();
        b1.start = 1'b0;
        checks++; if (b1.done !== 1'b1 || b1.busy !== 1'b0 || b1.count !== 16'h0) begin errors++; $display("FAIL zero pulse got=%h/%b/%b exp=0/0/1", b1.count, b1.busy, b1.done); end
        step();
        checks++; if (b1.done !== 1'b0 || b1.busy !== 1'b0) begin errors++; $display("FAIL zero after got=%b/%b exp=0/0", b1.busy, b1.done); end
    endtask

    task automatic test_ignored_start();
        b1.period    = 16'd20;
        b1.repeat_en = 1'b0;
        b1.start     = 1'b1;
        for (int c = 1; c <= 10; c++) sb.push_back(exp_t'{16'(21 - c), 1'b1, 1'b0});
        for (int c = 1; c <= 10; c++) begin
            step();
            b1.start = 1'b0;
            e = sb.pop_front();
            checks++; if (b1.count !== e.count) begin errors++; $display("FAIL ignstart count cyc=%0d got=%h exp=%h", c, b1.count, e.count); end
            checks++; if (b1.busy !== e.busy) begin errors++; $display("FAIL ignstart busy cyc=%0d got=%b exp=%b", c, b1.busy, e.busy); end
            checks++; if (b1.done !== e.done) begin errors++; $display("FAIL ignstart done cyc=%0d got=%b exp=%b", c, b1.done, e.done); end
            if (c == 4) begin
                b1.period = 16'd7;
                b1.start  = 1'b1;
            end
        end
        b1.abort = 1'b1;
        step();
        b1.abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        b1.period = 16'd10;
        b1.start  = 1'b1;
        step();
        b1.start = 1'b0;
        step();
        step();
        checks++; if (b1.count !== 16'd8) begin errors++; $display("FAIL rstmid pre got=%h exp=0008", b1.count); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (b1.count !== 16'h0 || b1.busy !== 1'b0 || b1.done !== 1'b0) begin errors++; $display("FAIL rstmid got=%h/%b/%b exp=0/0/0", b1.count, b1.busy, b1.done); end
        step();
        checks++; if (b1.done !== 1'b0 || b1.busy !== 1'b0) begin errors++; $display("FAIL rstmid after got=%b/%b exp=0/0", b1.busy, b1.done); end
    endtask

    task automatic test_long();
        int done_at;
        done_at   = -1;
        b1.period = 16'hFFFF;
        b1.start  = 1'b1;
        step();
        b1.start = 1'b0;
        for (int n = 0; n < 65540; n++) begin
            if (n == 0) begin
                checks++; if (b1.count !== 16'hFFFF) begin errors++; $display("FAIL long load got=%h exp=ffff", b1.count); end
            end
            if (n == 16'hFEFF) begin
                checks++; if (b1.count !== 16'h0100) begin errors++; $display("FAIL long b0100 got=%h exp=0100", b1.count); end
            end
            if (n == 16'hFF00) begin
                checks++; if (b1.count !== 16'h00FF) begin errors++; $display("FAIL long b00ff got=%h exp=00ff", b1.count); end
            end
            if (n == 16'hEFFF) begin
                checks++; if (b1.count !== 16'h1000) begin errors++; $display("FAIL long b1000 got=%h exp=1000", b1.count); end
            end
            if (n == 16'hF000) begin
                checks++; if (b1.count !== 16'h0FFF) begin errors++; $display("FAIL long b0fff got=%h exp=0fff", b1.count); end
            end
            if (b1.done === 1'b1) begin
                done_at = n;
                break;
            end
            step();
        end
        checks++; if (done_at != 65535) begin errors++; $display("FAIL long done_time got=%0d exp=65535", done_at); end
        checks++; if (b1.count !== 16'h0 || b1.busy !== 1'b0) begin errors++; $display("FAIL long end got=%h/%b exp=0/0", b1.count, b1.busy); end
        step();
        checks++; if (b1.done !== 1'b0) begin errors++; $display("FAIL long done_width got=%b exp=0", b1.done); end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        rst          = 1'b1;
        b1.start     = 1'b0;
        b1.period    = 16'h0;
        b1.repeat_en = 1'b0;
        b1.abort     = 1'b0;
        b4.start     = 1'b0;
        b4.period    = 16'h0;
        b4.repeat_en = 1'b0;
        b4.abort     = 1'b0;
        test_reset();
        test_oneshot();
        test_repeat();
        test_abort();
        test_zero();
        test_ignored_start();
        test_reset_mid();
        test_long();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
